// File: rtl/sdram_rdata_16b.sv
// Read-return path: tracks READ commands per bank and steers the returning burst words back to the issuing bank.
// Latency: word 0 is sampled CAS_LAT+IO_DLY edges after issue and presented in the following cycle.
// Backpressure: none; SDRAM data cannot be stalled, so consumers must accept whatever rd_valid marks.
module sdram_rdata_16b #(
    parameter int CAS_LAT   = 2,
    parameter int IO_DLY    = 2,
    parameter int BURST_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rd_issue,
    input  logic        rd_flush,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] rd_data,
    output logic [3:0]  rd_valid,
    output logic        rd_first,
    output logic        rd_last,
    output logic [2:0]  rd_widx,
    output logic        rd_ovl
);

    localparam int         LAT      = CAS_LAT + IO_DLY;
    localparam logic [2:0] LAST_IDX = 3'(BURST_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tag_q, tag_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ovl_d;

    logic [3:0] tag_pipe [LAT];
    logic [3:0] issue_one;
    logic       issue_multi;
    logic [3:0] tag_emerge;

    // Only the lowest requesting bank is tracked; extra bits are a protocol error.
    assign issue_one   = rd_issue & (~rd_issue + 4'd1);
    assign issue_multi = (rd_issue & (rd_issue - 4'd1)) != 4'd0;
    assign tag_emerge  = tag_pipe[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= 4'd0;
            end
        end else begin
            tag_pipe[0] <= rd_flush ? 4'd0 : issue_one;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= rd_flush ? 4'd0 : tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        ovl_d   = rd_ovl | (issue_multi & ~rd_flush);
        if (rd_flush) begin
            state_d = S_IDLE;
            tag_d   = 4'd0;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tag_emerge != 4'd0) begin
                        state_d = S_BURST;
                        tag_d   = tag_emerge;
                        cnt_d   = 3'd0;
                    end
                end
                S_BURST: begin
                    if (tag_emerge != 4'd0) begin
                        // A new burst always wins; cutting the old one short is an error.
                        if (cnt_q != LAST_IDX) begin
                            ovl_d = 1'b1;
                        end
                        tag_d = tag_emerge;
                        cnt_d = 3'd0;
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        tag_d   = 4'd0;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tag_d   = 4'd0;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= 4'd0;
            cnt_q   <= 3'd0;
            rd_ovl  <= 1'b0;
            rd_data <= 16'd0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            rd_ovl  <= ovl_d;
            rd_data <= sdram_dq_i;
        end
    end

    always_comb begin
        rd_valid = 4'd0;
        rd_first = 1'b0;
        rd_last  = 1'b0;
        rd_widx  = 3'd0;
        if (state_q == S_BURST) begin
            rd_valid = tag_q;
            rd_first = (cnt_q == 3'd0);
            rd_last  = (cnt_q == LAST_IDX);
            rd_widx  = cnt_q;
        end
    end

endmodule
